// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: sequencer state encodings,
// default counter width and the load-use detection helper.
package hazard_control_unit_pkg;

    // Default width of the datapath word and of the performance counters.
    localparam int WORD_SIZE = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        HCU_RUN     = 2'd0,
        HCU_DISCARD = 2'd1,
        HCU_HALT    = 2'd2
    } hcu_state_e;

    // True when the ID instruction reads the register that the load in EX
    // is about to write, so the consumer has to wait one cycle.
    function automatic logic hcu_load_use(
        input logic       d_read_ex,
        input logic [1:0] rs,
        input logic [1:0] rt,
        input logic       use_rs,
        input logic       use_rt,
        input logic [1:0] wr_ex
    );
        return d_read_ex & ((use_rs & (rs == wr_ex)) | (use_rt & (rt == wr_ex)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard status coming from the pipeline and the stall/flush/PC-write
// controls going back to it.
interface hazard_control_unit_if;

    // Hazard sources observed in the pipeline.
    logic [1:0] rs_ID;
    logic [1:0] rt_ID;
    logic       use_rs_ID;
    logic       use_rt_ID;
    logic       d_readM_EX;
    logic [1:0] write_reg_addr_EX;
    logic       redirect_EX;
    logic       redirect_ID;
    logic       i_ready;
    logic       d_req_MEM;
    logic       d_ready;
    logic       valid_WB;
    logic       is_halted_WB;

    // Controls for the PC and the four pipeline registers.
    logic       pc_write;
    logic       stall_IF_ID;
    logic       flush_IF_ID;
    logic       stall_ID_EX;
    logic       flush_ID_EX;
    logic       stall_EX_MEM;
    logic       flush_EX_MEM;
    logic       stall_MEM_WB;
    logic       flush_MEM_WB;

    // Pipeline side: reports hazards, obeys controls.
    modport master (
        output rs_ID, rt_ID, use_rs_ID, use_rt_ID, d_readM_EX, write_reg_addr_EX,
               redirect_EX, redirect_ID, i_ready, d_req_MEM, d_ready,
               valid_WB, is_halted_WB,
        input  pc_write, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX,
               stall_EX_MEM, flush_EX_MEM, stall_MEM_WB, flush_MEM_WB
    );

    // Sequencer side: reads hazards, drives controls.
    modport slave (
        input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, d_readM_EX, write_reg_addr_EX,
               redirect_EX, redirect_ID, i_ready, d_req_MEM, d_ready,
               valid_WB, is_halted_WB,
        output pc_write, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX,
               stall_EX_MEM, flush_EX_MEM, stall_MEM_WB, flush_MEM_WB
    );

endinterface

// File: rtl/hazard_perf_counter.sv
// Free-running event counter with increment enable and asynchronous
// active-low clear; wraps modulo 2^CNT_WIDTH.
module hazard_perf_counter
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_WIDTH = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 inc_en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_p0;

    // Count one event per enabled cycle; clear immediately on clear_n low.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_p0 <= '0;
        end else if (inc_en) begin
            count_p0 <= count_p0 + CNT_WIDTH'(1);
        end
    end

    assign count = count_p0;

endmodule

// File: rtl/hazard_control_unit.sv
// Central stall/flush sequencer for the 5-stage pipeline. Control outputs
// are combinational from the current state and hazard inputs; the state
// register tracks an outstanding wrong-path fetch and a latched halt.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_WIDTH = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hazard_control_unit_if.slave hz,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    hcu_state_e state_p0;
    hcu_state_e state_next;
    logic       load_use;
    logic       d_wait;
    logic       redirect;
    logic       retire_inc;
    logic       stall_inc;

    assign load_use = hcu_load_use(hz.d_readM_EX, hz.rs_ID, hz.rt_ID,
                                   hz.use_rs_ID, hz.use_rt_ID, hz.write_reg_addr_EX);
    assign d_wait   = hz.d_req_MEM & ~hz.d_ready;
    assign redirect = hz.redirect_EX | hz.redirect_ID;

    // State register: RUN / DISCARD / HALT, cleared to RUN on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p0 <= HCU_RUN;
        end else begin
            state_p0 <= state_next;
        end
    end

    // Priority-ordered hazard resolution and next-state selection.
    always_comb begin
        state_next      = state_p0;
        hz.pc_write     = 1'b0;
        hz.stall_IF_ID  = 1'b0;
        hz.flush_IF_ID  = 1'b0;
        hz.stall_ID_EX  = 1'b0;
        hz.flush_ID_EX  = 1'b0;
        hz.stall_EX_MEM = 1'b0;
        hz.flush_EX_MEM = 1'b0;
        hz.stall_MEM_WB = 1'b0;
        hz.flush_MEM_WB = 1'b0;

        if (!reset_n) begin
            // Drain every stage while reset is held.
            hz.flush_IF_ID  = 1'b1;
            hz.flush_ID_EX  = 1'b1;
            hz.flush_EX_MEM = 1'b1;
            hz.flush_MEM_WB = 1'b1;
            state_next      = HCU_RUN;
        end else if (state_p0 == HCU_HALT) begin
            hz.stall_IF_ID  = 1'b1;
            hz.stall_ID_EX  = 1'b1;
            hz.stall_EX_MEM = 1'b1;
            hz.stall_MEM_WB = 1'b1;
        end else if (d_wait) begin
            // Everything upstream of MEM freezes; WB receives a bubble.
            // State is held so a pending halt or discard resumes afterwards.
            hz.stall_IF_ID  = 1'b1;
            hz.stall_ID_EX  = 1'b1;
            hz.stall_EX_MEM = 1'b1;
            hz.flush_MEM_WB = 1'b1;
        end else begin
            if (redirect) begin
                // The ID instruction is wrong-path, so a load-use on it is moot.
                hz.pc_write    = 1'b1;
                hz.flush_IF_ID = 1'b1;
                hz.flush_ID_EX = hz.redirect_EX;
                // The fetch in flight was for the old PC; drop it when it lands.
                state_next     = hz.i_ready ? HCU_RUN : HCU_DISCARD;
            end else if (load_use) begin
                // Hold the consumer in ID and send a bubble to EX. Stall wins
                // over a concurrent fetch-wait flush of IF_ID; an outstanding
                // stale word stays pending because IF_ID does not capture it.
                hz.stall_IF_ID = 1'b1;
                hz.flush_ID_EX = 1'b1;
            end else if (state_p0 == HCU_DISCARD) begin
                // PC already points at the redirect target; just drop the word.
                hz.flush_IF_ID = 1'b1;
                if (hz.i_ready) begin
                    state_next = HCU_RUN;
                end
            end else if (!hz.i_ready) begin
                hz.flush_IF_ID = 1'b1;
            end else begin
                hz.pc_write = 1'b1;
            end

            if (hz.is_halted_WB) begin
                state_next = HCU_HALT;
            end
        end
    end

    assign halted     = (state_p0 == HCU_HALT);
    assign retire_inc = hz.valid_WB & (state_p0 != HCU_HALT);
    assign stall_inc  = ~hz.pc_write & (state_p0 != HCU_HALT) & reset_n;

    hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retired_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .inc_en  (retire_inc),
        .count   (retired_count)
    );

    hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .inc_en  (stall_inc),
        .count   (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: each driven cycle pushes the
// expected control vector, which is popped and compared once outputs settle.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          halted;
    logic [CW-1:0] retired_count;
    logic [CW-1:0] stall_cycles;
    logic [9:0]    ctl_vec;

    int n_tests;
    int n_fail;

    typedef struct {
        string      tag;
        logic [9:0] ctl;
    } exp_t;

    exp_t exp_q[$];

    hazard_control_unit_if hz();

    hazard_control_unit #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hz            (hz),
        .halted        (halted),
        .retired_count (retired_count),
        .stall_cycles  (stall_cycles)
    );

    // {pc_write, sIFID, fIFID, sIDEX, fIDEX, sEXMEM, fEXMEM, sMEMWB, fMEMWB, halted}
    assign ctl_vec = {hz.pc_write, hz.stall_IF_ID, hz.flush_IF_ID, hz.stall_ID_EX,
                      hz.flush_ID_EX, hz.stall_EX_MEM, hz.flush_EX_MEM,
                      hz.stall_MEM_WB, hz.flush_MEM_WB, halted};

    localparam logic [9:0] C_RESET = 10'b0_01_01_01_01_0;
    localparam logic [9:0] C_NORM  = 10'b1_00_00_00_00_0;
    localparam logic [9:0] C_LU    = 10'b0_10_01_00_00_0;
    localparam logic [9:0] C_REX   = 10'b1_01_01_00_00_0;
    localparam logic [9:0] C_RID   = 10'b1_01_00_00_00_0;
    localparam logic [9:0] C_FLIF  = 10'b0_01_00_00_00_0;
    localparam logic [9:0] C_DWAIT = 10'b0_10_10_10_01_0;
    localparam logic [9:0] C_HALT  = 10'b0_10_10_10_10_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied just after a negedge; compare, then move on.
    task automatic cycle(input string tag, input logic [9:0] exp);
        exp_t e;
        exp_q.push_back('{tag, exp});
        #1;
        e = exp_q.pop_front();
        check_val(e.tag, 32'(ctl_vec), 32'(e.ctl));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hz.rs_ID             = 2'd0;
        hz.rt_ID             = 2'd0;
        hz.use_rs_ID         = 1'b0;
        hz.use_rt_ID         = 1'b0;
        hz.d_readM_EX        = 1'b0;
        hz.write_reg_addr_EX = 2'd0;
        hz.redirect_EX       = 1'b0;
        hz.redirect_ID       = 1'b0;
        hz.i_ready           = 1'b1;
        hz.d_req_MEM         = 1'b0;
        hz.d_ready           = 1'b1;
        hz.valid_WB          = 1'b0;
        hz.is_halted_WB      = 1'b0;
    endtask

    task automatic set_load_use(input logic [1:0] rs, input logic [1:0] rt,
                                input logic urs, input logic urt);
        hz.d_readM_EX        = 1'b1;
        hz.write_reg_addr_EX = 2'd1;
        hz.rs_ID             = rs;
        hz.rt_ID             = rt;
        hz.use_rs_ID         = urs;
        hz.use_rt_ID         = urt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        cycle("reset_ctl", C_RESET);
        check_val("reset_ret", 32'(retired_count), 32'd0);
        check_val("reset_stl", 32'(stall_cycles), 32'd0);
        reset_n = 1'b1;

        // Load-use detection
        cycle("norm", C_NORM);
        set_load_use(2'd1, 2'd2, 1'b1, 1'b1);
        cycle("lu_rs", C_LU);
        hz.use_rs_ID = 1'b0;
        cycle("lu_no_use", C_NORM);
        set_load_use(2'd0, 2'd1, 1'b1, 1'b1);
        cycle("lu_rt", C_LU);
        hz.d_readM_EX = 1'b0;
        cycle("no_load", C_NORM);
        check_val("stall_cnt_lu", 32'(stall_cycles), 32'd2);

        // Redirects with instruction ready
        idle_inputs();
        hz.redirect_EX = 1'b1;
        cycle("rex", C_REX);
        set_load_use(2'd1, 2'd1, 1'b1, 1'b1);
        cycle("rex_lu", C_REX);
        idle_inputs();
        cycle("rex_stays_run", C_NORM);
        hz.redirect_ID = 1'b1;
        cycle("rid", C_RID);
        check_val("stall_cnt_rdr", 32'(stall_cycles), 32'd2);

        // Redirect during a fetch wait, then discard of the stale word
        hz.i_ready = 1'b0;
        cycle("rid_wait", C_RID);
        hz.redirect_ID = 1'b0;
        cycle("disc1", C_FLIF);
        cycle("disc2", C_FLIF);
        hz.i_ready = 1'b1;
        cycle("disc_arrive", C_FLIF);
        cycle("run_after_disc", C_NORM);
        check_val("stall_cnt_disc", 32'(stall_cycles), 32'd5);

        // Plain fetch wait, and fetch wait combined with load-use
        hz.i_ready = 1'b0;
        cycle("fetch_wait", C_FLIF);
        set_load_use(2'd1, 2'd0, 1'b1, 1'b0);
        cycle("fw_lu", C_LU);
        idle_inputs();
        cycle("fw_done", C_NORM);

        // Data-memory wait with a redirect held
        hz.d_req_MEM   = 1'b1;
        hz.d_ready     = 1'b0;
        hz.redirect_EX = 1'b1;
        for (int i = 0; i < 4; i++) cycle($sformatf("dwait%0d", i), C_DWAIT);
        hz.d_ready = 1'b1;
        cycle("dwait_rdr", C_REX);
        idle_inputs();
        cycle("dwait_done", C_NORM);
        check_val("stall_cnt_dw", 32'(stall_cycles), 32'd11);
        check_val("ret_before", 32'(retired_count), 32'd0);

        // Retire five, then HLT
        hz.valid_WB = 1'b1;
        for (int i = 0; i < 5; i++) cycle($sformatf("retire%0d", i), C_NORM);
        hz.is_halted_WB = 1'b1;
        cycle("hlt_wb", C_NORM);
        idle_inputs();
        cycle("halt1", C_HALT);
        check_val("ret_halt", 32'(retired_count), 32'd6);
        hz.valid_WB    = 1'b1;
        hz.redirect_EX = 1'b1;
        hz.i_ready     = 1'b0;
        cycle("halt2", C_HALT);
        check_val("ret_halt_hold", 32'(retired_count), 32'd6);
        check_val("stl_halt_hold", 32'(stall_cycles), 32'd11);

        // Asynchronous reset mid-halt, away from any clock edge
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_halted", 32'(halted), 32'd0);
        check_val("async_ret", 32'(retired_count), 32'd0);
        check_val("async_stl", 32'(stall_cycles), 32'd0);
        check_val("async_ctl", 32'(ctl_vec), 32'(C_RESET));
        @(negedge clk);
        reset_n = 1'b1;
        cycle("post_reset", C_NORM);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
